adc_pll_rst_ctrl: RTL
=====================

ADC_PLL_RST_CTRL -- requirements
Module: adc_pll_rst_ctrl

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, default 16, which sets the number of cycles pll_rst is held high per attempt.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, which sets the number of consecutive synchronized-locked cycles required before release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536, which sets the maximum number of cycles spent in WAIT_LOCK per attempt.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, which sets the number of re-attempts allowed before FAULT.
REQ-005 SHALL have port refclk, input, 1 bit: the single clock (50 MHz reference); all logic runs on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL lock flag, asynchronous to refclk.
REQ-008 SHALL have port restart, input, 1 bit: a single-cycle request to re-run the sequence.
REQ-009 SHALL have port pll_rst, output, 1 bit: active-high reset to the PLL.
REQ-010 SHALL have port sys_rst_n, output, 1 bit: active-low reset for logic on the PLL output clocks.
REQ-011 SHALL have port ready, output, 1 bit, asserted in RUN, and port fault, output, 1 bit, asserted in FAULT.
REQ-012 SHALL have port retry_cnt, output, 2 bits, and port lol_cnt, output, 8 bits.

Function
REQ-013 SHALL pass pll_locked through a 2-flop synchronizer to produce lock_s; lock_s lags pll_locked by 2 cycles.
REQ-014 SHALL implement the states RESET_PLL, WAIT_LOCK, STABLE, RUN and FAULT, with one shared cycle counter that is cleared on every state entry.
REQ-015 In RESET_PLL, SHALL drive pll_rst=1; when the counter reaches RST_HOLD_CYCLES-1, SHALL go to WAIT_LOCK.
REQ-016 In WAIT_LOCK, SHALL drive pll_rst=0; when lock_s=1, SHALL go to STABLE.
REQ-017 In WAIT_LOCK, when the counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0, SHALL go to FAULT if retry_cnt==MAX_RETRIES; otherwise SHALL increment retry_cnt and go to RESET_PLL.
REQ-018 In STABLE, if lock_s=0, SHALL go to WAIT_LOCK; the timeout window restarts and retry_cnt is unchanged.
REQ-019 In STABLE, when the counter reaches LOCK_STABLE_CYCLES-1 with lock_s=1, SHALL go to RUN.
REQ-020 In RUN, SHALL drive sys_rst_n=1 and ready=1 from the first RUN cycle, and SHALL clear retry_cnt on RUN entry.
REQ-021 In RUN, on lock_s=0 (loss of lock), SHALL go to RESET_PLL and drive sys_rst_n=0 and ready=0 in the same registered update.
REQ-022 In FAULT, SHALL drive pll_rst=1, fault=1 and sys_rst_n=0, and SHALL remain in FAULT until restart or reset.
REQ-023 restart=1 in any state SHALL force RESET_PLL, clear retry_cnt and clear fault; restart takes priority over every lock and timeout event in the same cycle.
REQ-024 sys_rst_n SHALL be 0 in every state other than RUN, and all outputs SHALL be registered.
REQ-025 The counter width SHALL be $clog2 of the largest of the three cycle parameters; the counter SHALL never wrap.

Reset
REQ-026 While rst_n=0 on a rising edge, SHALL set state=RESET_PLL, pll_rst=1, sys_rst_n=0, ready=0, fault=0, retry_cnt=0, lol_cnt=0, counter=0 and both synchronizer flops=0.
REQ-027 Reset asserted mid-sequence, including in RUN or FAULT, SHALL take effect on the next edge and restart the sequence from RESET_PLL.

Configuration
REQ-028 SHALL provide macro ADC_PLL_LOL_COUNTER_EN.
- Defined: lol_cnt increments on each RUN-to-RESET_PLL loss-of-lock transition, saturates at 255, and is cleared only by rst_n.
- Undefined: lol_cnt is tied to 0 and no counter logic is synthesized.

Structure
REQ-029 SHALL place the state enum type, the retry_cnt width (2) and the lol_cnt width (8) in the shared package adc_pll_ctrl_pkg.
REQ-030 SHALL implement the synchronizer as the sub-module sync_2ff, with ports clk, rst_n, d and q.

Verification
Bench parameters for all scenarios: RST_HOLD_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
REQ-031 Clean lock: release rst_n, raise pll_locked 10 cycles later and hold it.
- pll_rst is high for exactly 4 cycles.
- sys_rst_n and ready rise 2+8 cycles after pll_locked rises.
REQ-032 Never locked: hold pll_locked=0.
- Three PLL reset pulses occur, each 4 cycles long, 32 cycles apart.
- retry_cnt steps 1 then 2.
- FAULT is entered with fault=1 and pll_rst=1 held.
REQ-033 Glitch during STABLE: drop pll_locked for 1 cycle at STABLE count 5.
- State returns to WAIT_LOCK, then goes to STABLE again.
- ready rises only after 8 fresh consecutive locked cycles.
REQ-034 Loss of lock: with the block in RUN, drop pll_locked.
- sys_rst_n goes low 3 cycles later.
- A new 4-cycle pll_rst pulse follows.
- With the macro defined, lol_cnt becomes 1; after 256 such events it stays at 255.
REQ-035 Restart priority: pulse restart while in FAULT, and separately on the same cycle as the lock_s rise in WAIT_LOCK.
- Both cases go to RESET_PLL with fault=0 and retry_cnt=0.
REQ-036 Reset mid-operation: assert rst_n=0 for 1 cycle while in RUN.
- The next cycle shows all REQ-026 values.

Source files
------------

// File: rtl/adc_pll_ctrl_pkg.sv
// Shared types and widths for the ADC PLL reset controller.
// Holds the controller state encoding, the retry/loss-of-lock counter
// widths and a small helper used to size the shared cycle counter.
package adc_pll_ctrl_pkg;

   localparam int RETRY_W = 2;
   localparam int LOL_W   = 8;

   typedef enum logic [2:0] {
      ST_RESET_PLL = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } pll_state_e;

   // Largest of three cycle parameters; sizes the shared counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) begin
         m = b;
      end else begin
         m = m;
      end
      if (c > m) begin
         m = c;
      end else begin
         m = m;
      end
      return m;
   endfunction

endpackage

// File: rtl/adc_pll_rst_ctrl_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into the
// reference clock domain. Both stages clear on synchronous active-low reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/adc_pll_rst_ctrl.sv
// ADC PLL reset sequencer: pulses the PLL reset, waits for lock, requires a
// stable lock window before releasing the downstream reset, retries on lock
// timeout and parks in FAULT once the retries are used up.
// Optional feature macro: ADC_PLL_LOL_COUNTER_EN (saturating loss-of-lock
// event counter on lol_cnt; tied to zero when undefined).
module adc_pll_rst_ctrl
   import adc_pll_ctrl_pkg::*;
#(
   parameter int RST_HOLD_CYCLES     = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 3
) (
   input  logic               refclk,
   input  logic               rst_n,
   input  logic               pll_locked,
   input  logic               restart,
   output logic               pll_rst,
   output logic               sys_rst_n,
   output logic               ready,
   output logic               fault,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [LOL_W-1:0]   lol_cnt
);

   localparam int CNT_MAX_VAL = max3(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
   localparam int CNT_W       = ($clog2(CNT_MAX_VAL) < 1) ? 1 : $clog2(CNT_MAX_VAL);

   localparam logic [CNT_W-1:0]   CNT_SAT     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

   logic lock_s;

   pll_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               pll_rst_q, pll_rst_d;
   logic               sys_rst_n_q, sys_rst_n_d;
   logic               ready_q, ready_d;
   logic               fault_q, fault_d;

   sync_2ff u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (lock_s)
   );

   // Next-state, shared counter, retry bookkeeping and output decode.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      if (restart) begin
         state_d = ST_RESET_PLL;
         retry_d = {RETRY_W{1'b0}};
      end else begin
         case (state_q)
            ST_RESET_PLL: begin
               if (cnt_q == RST_LAST) begin
                  state_d = ST_WAIT_LOCK;
               end else begin
                  state_d = ST_RESET_PLL;
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state_d = ST_STABLE;
               end else if (cnt_q == TMO_LAST) begin
                  if (retry_q == RETRY_LIMIT) begin
                     state_d = ST_FAULT;
                  end else begin
                     state_d = ST_RESET_PLL;
                     retry_d = retry_q + RETRY_W'(1);
                  end
               end else begin
                  state_d = ST_WAIT_LOCK;
               end
            end
            ST_STABLE: begin
               if (!lock_s) begin
                  state_d = ST_WAIT_LOCK;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = ST_RUN;
                  retry_d = {RETRY_W{1'b0}};
               end else begin
                  state_d = ST_STABLE;
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state_d = ST_RESET_PLL;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_FAULT: begin
               state_d = ST_FAULT;
            end
            default: begin
               state_d = ST_RESET_PLL;
            end
         endcase
      end

      // Counter restarts on every state entry (restart re-enters RESET_PLL)
      // and holds at all-ones rather than wrapping.
      if (restart || (state_d != state_q)) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q != CNT_SAT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end

      // Outputs follow the next state so they change with the state register.
      case (state_d)
         ST_RESET_PLL: begin
            pll_rst_d   = 1'b1;
            sys_rst_n_d = 1'b0;
            ready_d     = 1'b0;
            fault_d     = 1'b0;
         end
         ST_RUN: begin
            pll_rst_d   = 1'b0;
            sys_rst_n_d = 1'b1;
            ready_d     = 1'b1;
            fault_d     = 1'b0;
         end
         ST_FAULT: begin
            pll_rst_d   = 1'b1;
            sys_rst_n_d = 1'b0;
            ready_d     = 1'b0;
            fault_d     = 1'b1;
         end
         default: begin
            pll_rst_d   = 1'b0;
            sys_rst_n_d = 1'b0;
            ready_d     = 1'b0;
            fault_d     = 1'b0;
         end
      endcase
   end

   // Controller state and registered outputs.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state_q     <= ST_RESET_PLL;
         cnt_q       <= {CNT_W{1'b0}};
         retry_q     <= {RETRY_W{1'b0}};
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
         fault_q     <= fault_d;
      end
   end

   assign pll_rst   = pll_rst_q;
   assign sys_rst_n = sys_rst_n_q;
   assign ready     = ready_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;

`ifdef ADC_PLL_LOL_COUNTER_EN
   logic             lol_event_s;
   logic [LOL_W-1:0] lol_q, lol_d;

   // A loss of lock is a lock-driven RUN exit; a restart is not counted.
   always_comb begin
      lol_event_s = (state_q == ST_RUN) && (state_d == ST_RESET_PLL) && !restart;
      if (lol_event_s && (lol_q != {LOL_W{1'b1}})) begin
         lol_d = lol_q + LOL_W'(1);
      end else begin
         lol_d = lol_q;
      end
   end

   // Saturating loss-of-lock counter, cleared only by rst_n.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         lol_q <= {LOL_W{1'b0}};
      end else begin
         lol_q <= lol_d;
      end
   end

   assign lol_cnt = lol_q;
`else
   assign lol_cnt = {LOL_W{1'b0}};
`endif

endmodule
